// File: rtl/prog_result_checker_if.sv
// rtl/prog_result_checker_if.sv - config, CPU-monitor and result signals of prog_result_checker
interface prog_result_checker_if #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_W     = 6,
    parameter int CYC_W     = 16
);
    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic                 cfg_en;
    logic [WORD_SIZE-1:0] cfg_num_inst;
    logic [WORD_SIZE-1:0] cfg_ans;
    logic                 start;
    logic [WORD_SIZE-1:0] num_inst;
    logic [WORD_SIZE-1:0] output_port;
    logic                 is_halted;
    logic [IDX_W-1:0]     rd_idx;
    logic [1:0]           rd_status;
    logic                 running;
    logic                 done;
    logic                 timeout;
    logic [IDX_W:0]       pass_count;
    logic [IDX_W:0]       fail_count;
    logic [IDX_W:0]       enabled_count;
    logic                 all_pass;
    logic [IDX_W-1:0]     first_fail_idx;
    logic                 first_fail_valid;
    logic [CYC_W-1:0]     cycle_count;

    modport slave (
        input  cfg_we, cfg_idx, cfg_en, cfg_num_inst, cfg_ans, start,
        input  num_inst, output_port, is_halted, rd_idx,
        output rd_status, running, done, timeout, pass_count, fail_count,
        output enabled_count, all_pass, first_fail_idx, first_fail_valid, cycle_count
    );

    modport master (
        output cfg_we, cfg_idx, cfg_en, cfg_num_inst, cfg_ans, start,
        output num_inst, output_port, is_halted, rd_idx,
        input  rd_status, running, done, timeout, pass_count, fail_count,
        input  enabled_count, all_pass, first_fail_idx, first_fail_valid, cycle_count
    );
endinterface

// File: rtl/prog_result_checker.sv
// rtl/prog_result_checker.sv - table of expected (num_inst, output_port) pairs checked live against a CPU
module prog_result_checker #(
    parameter int WORD_SIZE    = 16,
    parameter int NUM_TEST     = 64,
    parameter int IDX_W        = 6,
    parameter int CYC_W        = 16,
    parameter int MAX_CYCLES   = 10000,
    parameter int STOP_ON_FAIL = 1
) (
    input logic                  clk,
    input logic                  reset,
    prog_result_checker_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CYC_W-1:0] LP_CYC_LAST = CYC_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W:0]   LP_NUM_TEST = (IDX_W+1)'(NUM_TEST);

    state_t r_state;
    state_t w_state_next;

    logic [NUM_TEST-1:0]  r_en;
    logic [WORD_SIZE-1:0] r_exp_ni  [NUM_TEST];
    logic [WORD_SIZE-1:0] r_exp_ans [NUM_TEST];
    logic [1:0]           r_status  [NUM_TEST];

    logic [IDX_W:0]   r_pass_count;
    logic [IDX_W:0]   r_fail_count;
    logic [IDX_W:0]   r_enabled_count;
    logic [CYC_W-1:0] r_cycle_count;
    logic             r_timeout;
    logic             r_ff_valid;
    logic [IDX_W-1:0] r_ff_idx;

    logic [NUM_TEST-1:0] w_hit;
    logic [NUM_TEST-1:0] w_pass;
    logic [NUM_TEST-1:0] w_fail;
    logic [IDX_W:0]      w_pass_inc;
    logic [IDX_W:0]      w_fail_inc;
    logic [IDX_W-1:0]    w_fail_low;
    logic                w_any_fail;
    logic                w_cyc_last;
    logic                w_arm;
    logic                w_cfg_ok;
    logic                w_rd_ok;
    logic                w_cfg_wr;

    // Index range checks fold away when the index width exactly covers the table.
    generate
        if (NUM_TEST >= (1 << IDX_W)) begin : g_full_idx
            assign w_cfg_ok = 1'b1;
            assign w_rd_ok  = 1'b1;
        end else begin : g_part_idx
            assign w_cfg_ok = ({1'b0, bus.cfg_idx} < LP_NUM_TEST);
            assign w_rd_ok  = ({1'b0, bus.rd_idx} < LP_NUM_TEST);
        end
    endgenerate

    assign w_arm      = bus.start && (r_state != S_RUN);
    assign w_cfg_wr   = (r_state == S_IDLE) && bus.cfg_we && !bus.start && w_cfg_ok;
    assign w_cyc_last = (r_cycle_count == LP_CYC_LAST);
    assign w_any_fail = |w_fail;

    always_comb begin
        w_hit      = '0;
        w_pass     = '0;
        w_fail     = '0;
        w_pass_inc = '0;
        w_fail_inc = '0;
        w_fail_low = '0;
        // Descending scan so the last assignment leaves the lowest failing index.
        for (int i = NUM_TEST - 1; i >= 0; i--) begin
            w_hit[i]   = (r_state == S_RUN) && r_en[i] && (r_status[i] == 2'b00)
                         && (r_exp_ni[i] == bus.num_inst);
            w_pass[i]  = w_hit[i] && (r_exp_ans[i] == bus.output_port);
            w_fail[i]  = w_hit[i] && (r_exp_ans[i] != bus.output_port);
            w_pass_inc = w_pass_inc + (IDX_W+1)'(w_pass[i]);
            w_fail_inc = w_fail_inc + (IDX_W+1)'(w_fail[i]);
            if (w_fail[i]) begin
                w_fail_low = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.is_halted || ((STOP_ON_FAIL != 0) && w_any_fail) || w_cyc_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en            <= '0;
            r_enabled_count <= '0;
            for (int i = 0; i < NUM_TEST; i++) begin
                r_exp_ni[i]  <= '0;
                r_exp_ans[i] <= '0;
            end
        end else if (w_cfg_wr) begin
            r_en[bus.cfg_idx]      <= bus.cfg_en;
            r_exp_ni[bus.cfg_idx]  <= bus.cfg_num_inst;
            r_exp_ans[bus.cfg_idx] <= bus.cfg_ans;
            if (bus.cfg_en && !r_en[bus.cfg_idx]) begin
                r_enabled_count <= r_enabled_count + 1'b1;
            end else if (!bus.cfg_en && r_en[bus.cfg_idx]) begin
                r_enabled_count <= r_enabled_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TEST; i++) begin
                r_status[i] <= 2'b00;
            end
            r_pass_count  <= '0;
            r_fail_count  <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_ff_valid    <= 1'b0;
            r_ff_idx      <= '0;
        end else if (w_arm) begin
            for (int i = 0; i < NUM_TEST; i++) begin
                r_status[i] <= 2'b00;
            end
            r_pass_count  <= '0;
            r_fail_count  <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_ff_valid    <= 1'b0;
            r_ff_idx      <= '0;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < NUM_TEST; i++) begin
                if (w_hit[i]) begin
                    r_status[i] <= w_pass[i] ? 2'b01 : 2'b10;
                end
            end
            r_pass_count <= r_pass_count + w_pass_inc;
            r_fail_count <= r_fail_count + w_fail_inc;
            if (w_cyc_last) begin
                r_timeout <= 1'b1;
            end else begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
            if (w_any_fail && !r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_idx   <= w_fail_low;
            end
        end
    end

    assign bus.rd_status        = w_rd_ok ? r_status[bus.rd_idx] : 2'b00;
    assign bus.running          = (r_state == S_RUN);
    assign bus.done             = (r_state == S_DONE);
    assign bus.timeout          = r_timeout;
    assign bus.pass_count       = r_pass_count;
    assign bus.fail_count       = r_fail_count;
    assign bus.enabled_count    = r_enabled_count;
    assign bus.all_pass         = (r_state == S_DONE) && (r_pass_count == r_enabled_count) && !r_timeout;
    assign bus.first_fail_idx   = r_ff_idx;
    assign bus.first_fail_valid = r_ff_valid;
    assign bus.cycle_count      = r_cycle_count;
endmodule

// File: tb/tb_prog_result_checker.sv
// tb/tb_prog_result_checker.sv - two checker instances (stop-on-fail / keep-running) against a behavioural model
module tb_prog_result_checker;
    localparam int WS     = 16;
    localparam int NT     = 6;
    localparam int IW     = 3;
    localparam int CW     = 16;
    localparam int MAXC_A = 20;
    localparam int MAXC_B = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          cfg_we, cfg_en, start, is_halted;
    logic [IW-1:0] cfg_idx, rd_idx;
    logic [WS-1:0] cfg_num_inst, cfg_ans, num_inst, output_port;

    int checks   = 0;
    int failures = 0;

    prog_result_checker_if #(.WORD_SIZE(WS), .IDX_W(IW), .CYC_W(CW)) if_a ();
    prog_result_checker_if #(.WORD_SIZE(WS), .IDX_W(IW), .CYC_W(CW)) if_b ();

    assign if_a.cfg_we = cfg_we;             assign if_b.cfg_we = cfg_we;
    assign if_a.cfg_idx = cfg_idx;           assign if_b.cfg_idx = cfg_idx;
    assign if_a.cfg_en = cfg_en;             assign if_b.cfg_en = cfg_en;
    assign if_a.cfg_num_inst = cfg_num_inst; assign if_b.cfg_num_inst = cfg_num_inst;
    assign if_a.cfg_ans = cfg_ans;           assign if_b.cfg_ans = cfg_ans;
    assign if_a.start = start;               assign if_b.start = start;
    assign if_a.num_inst = num_inst;         assign if_b.num_inst = num_inst;
    assign if_a.output_port = output_port;   assign if_b.output_port = output_port;
    assign if_a.is_halted = is_halted;       assign if_b.is_halted = is_halted;
    assign if_a.rd_idx = rd_idx;             assign if_b.rd_idx = rd_idx;

    prog_result_checker #(.WORD_SIZE(WS), .NUM_TEST(NT), .IDX_W(IW), .CYC_W(CW),
                          .MAX_CYCLES(MAXC_A), .STOP_ON_FAIL(1))
        u_stop (.clk(clk), .reset(reset), .bus(if_a));

    prog_result_checker #(.WORD_SIZE(WS), .NUM_TEST(NT), .IDX_W(IW), .CYC_W(CW),
                          .MAX_CYCLES(MAXC_B), .STOP_ON_FAIL(0))
        u_cont (.clk(clk), .reset(reset), .bus(if_b));

    // Model: per instance, 0 = idle, 1 = run, 2 = done; statuses 0 none, 1 pass, 2 wrong.
    int m_state [2];
    bit m_en    [2][NT];
    int m_ni    [2][NT];
    int m_ans   [2][NT];
    int m_st    [2][NT];
    int m_cyc   [2];
    bit m_to    [2];
    int m_ffi   [2];
    bit m_ffv   [2];

    function automatic int maxc_of(input int k);
        return (k == 0) ? MAXC_A : MAXC_B;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=0x%0h expected=0x%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_clear_run(input int k);
        for (int i = 0; i < NT; i++) m_st[k][i] = 0;
        m_cyc[k] = 0; m_to[k] = 0; m_ffi[k] = 0; m_ffv[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            model_clear_run(k);
            for (int i = 0; i < NT; i++) begin
                m_en[k][i] = 0; m_ni[k][i] = 0; m_ans[k][i] = 0;
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_state[k] != 1 && start) begin
                model_clear_run(k);
                m_state[k] = 1;
            end else if (m_state[k] == 0 && cfg_we && int'(cfg_idx) < NT) begin
                m_en[k][cfg_idx]  = cfg_en;
                m_ni[k][cfg_idx]  = int'(cfg_num_inst);
                m_ans[k][cfg_idx] = int'(cfg_ans);
            end else if (m_state[k] == 1) begin
                int low = -1;
                int cb  = m_cyc[k];
                for (int i = 0; i < NT; i++) begin
                    if (m_en[k][i] && m_st[k][i] == 0 && m_ni[k][i] == int'(num_inst)) begin
                        if (m_ans[k][i] == int'(output_port)) m_st[k][i] = 1;
                        else begin
                            m_st[k][i] = 2;
                            if (low < 0) low = i;
                        end
                    end
                end
                if (low >= 0 && !m_ffv[k]) begin
                    m_ffv[k] = 1; m_ffi[k] = low;
                end
                if (cb == maxc_of(k) - 1) m_to[k] = 1;
                else m_cyc[k] = cb + 1;
                if (is_halted || (k == 0 && low >= 0) || cb == maxc_of(k) - 1) m_state[k] = 2;
            end
        end
    endtask

    task automatic cmp(input int k, input logic run, input logic dn, input logic to,
                       input logic [IW:0] pc, input logic [IW:0] fc, input logic [IW:0] ec,
                       input logic ap, input logic [IW-1:0] ffi, input logic ffv,
                       input logic [CW-1:0] cc, input logic [1:0] rs);
        int ep = 0;
        int ef = 0;
        int ee = 0;
        for (int i = 0; i < NT; i++) begin
            if (m_st[k][i] == 1) ep++;
            if (m_st[k][i] == 2) ef++;
            if (m_en[k][i]) ee++;
        end
        chk("running", k, run, m_state[k] == 1);
        chk("done", k, dn, m_state[k] == 2);
        chk("timeout", k, to, m_to[k]);
        chk("pass_count", k, pc, ep);
        chk("fail_count", k, fc, ef);
        chk("enabled_count", k, ec, ee);
        chk("all_pass", k, ap, (m_state[k] == 2) && (ep == ee) && !m_to[k]);
        chk("first_fail_idx", k, ffi, m_ffi[k]);
        chk("first_fail_valid", k, ffv, m_ffv[k]);
        chk("cycle_count", k, cc, m_cyc[k]);
        chk("rd_status", k, rs, (int'(rd_idx) < NT) ? m_st[k][rd_idx] : 0);
    endtask

    always @(negedge clk) begin
        cmp(0, if_a.running, if_a.done, if_a.timeout, if_a.pass_count, if_a.fail_count,
            if_a.enabled_count, if_a.all_pass, if_a.first_fail_idx, if_a.first_fail_valid,
            if_a.cycle_count, if_a.rd_status);
        cmp(1, if_b.running, if_b.done, if_b.timeout, if_b.pass_count, if_b.fail_count,
            if_b.enabled_count, if_b.all_pass, if_b.first_fail_idx, if_b.first_fail_valid,
            if_b.cycle_count, if_b.rd_status);
    end

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b1; model_reset();
        cfg_we = 0; cfg_en = 0; start = 0; is_halted = 0;
        cfg_idx = 0; rd_idx = 0; cfg_num_inst = 0; cfg_ans = 0; num_inst = 0; output_port = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic wr(input int idx, input bit en, input int ni, input int ans);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_en = en; cfg_num_inst = WS'(ni); cfg_ans = WS'(ans);
        tick();
        cfg_we = 0;
    endtask

    task automatic go();
        start = 1; tick(); start = 0;
    endtask

    task automatic drive(input int ni, input int op);
        num_inst = WS'(ni); output_port = WS'(op); tick();
    endtask

    task automatic halt();
        is_halted = 1; tick(); is_halted = 0;
    endtask

    function automatic int pick_word(input int r);
        case (r)
            0: return 0;
            1: return 1;
            2: return 2;
            default: return 16'hFFFF;
        endcase
    endfunction

    initial begin
        do_reset();
        chk("rst_done", 0, if_a.done, 0);
        chk("rst_enabled", 1, if_b.enabled_count, 0);
        chk("rst_rd_status", 0, if_a.rd_status, 0);

        // Basic pass run, halt at num_inst 6
        wr(0, 1, 3, 16'h0000);
        wr(1, 1, 5, 16'h0002);
        wr(7, 1, 9, 16'h0009);
        chk("oor_write_ignored", 0, if_a.enabled_count, 2);
        go();
        for (int n = 0; n < 6; n++) drive(n, (n == 3) ? 0 : (n == 5) ? 2 : n);
        num_inst = 6; halt();
        rd_idx = 1; #1;
        chk("t1_done", 0, if_a.done, 1);
        chk("t1_pass", 1, if_b.pass_count, 2);
        chk("t1_fail", 0, if_a.fail_count, 0);
        chk("t1_all_pass", 0, if_a.all_pass, 1);
        chk("t1_rd_status1", 1, if_b.rd_status, 2'b01);
        chk("t1_cycles", 0, if_a.cycle_count, 7);

        // Single failure: stop instance ends, continue instance keeps running
        do_reset();
        wr(2, 1, 7, 16'hFFFE);
        go();
        drive(7, 16'hFFFD);
        rd_idx = 2; #1;
        chk("t2_done", 0, if_a.done, 1);
        chk("t2_rd_status2", 0, if_a.rd_status, 2'b10);
        chk("t2_ffi", 0, if_a.first_fail_idx, 2);
        chk("t2_ffv", 0, if_a.first_fail_valid, 1);
        chk("t2_all_pass", 0, if_a.all_pass, 0);
        chk("t2_cont_running", 1, if_b.running, 1);
        halt();

        // Two failures on different edges plus a pass on the second edge
        do_reset();
        wr(0, 1, 2, 16'h0011);
        wr(1, 1, 4, 16'h0022);
        wr(2, 1, 4, 16'h0055);
        go();
        drive(2, 0);
        drive(4, 16'h0055);
        chk("t3_running", 1, if_b.running, 1);
        chk("t3_fail", 1, if_b.fail_count, 2);
        chk("t3_pass", 1, if_b.pass_count, 1);
        chk("t3_ffi", 1, if_b.first_fail_idx, 0);
        chk("t3_stop_fail", 0, if_a.fail_count, 1);
        halt();
        chk("t3_done", 1, if_b.done, 1);

        // Timeout on the 20-cycle instance
        do_reset();
        wr(0, 1, 100, 1);
        go();
        num_inst = 0;
        repeat (19) tick();
        chk("t4_still_running", 0, if_a.running, 1);
        chk("t4_cyc19", 0, if_a.cycle_count, 19);
        tick();
        rd_idx = 0; #1;
        chk("t4_done", 0, if_a.done, 1);
        chk("t4_timeout", 0, if_a.timeout, 1);
        chk("t4_cyc_sat", 0, if_a.cycle_count, 19);
        chk("t4_rd_status0", 0, if_a.rd_status, 2'b00);
        chk("t4_all_pass", 0, if_a.all_pass, 0);
        chk("t4_cont_cyc", 1, if_b.cycle_count, 20);
        halt();

        // Sticky status
        do_reset();
        wr(0, 1, 3, 5);
        go();
        drive(3, 5);
        repeat (3) drive(3, 0);
        rd_idx = 0; #1;
        chk("t5_status", 0, if_a.rd_status, 2'b01);
        chk("t5_pass", 1, if_b.pass_count, 1);
        chk("t5_fail", 0, if_a.fail_count, 0);
        halt();

        // Re-arm from DONE, then asynchronous reset mid-run
        go();
        drive(0, 0);
        drive(1, 0);
        reset = 1'b1; model_reset(); #1;
        chk("t6_running", 0, if_a.running, 0);
        chk("t6_cycles", 1, if_b.cycle_count, 0);
        chk("t6_enabled", 0, if_a.enabled_count, 0);
        tick(); tick();
        reset = 1'b0;
        go();
        halt();
        chk("t6_empty_all_pass", 0, if_a.all_pass, 1);
        chk("t6_empty_all_pass", 1, if_b.all_pass, 1);

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 2) == 0) do_reset();
            repeat ($urandom_range(0, 8)) begin
                wr($urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
                   $urandom_range(0, 7), pick_word($urandom_range(0, 3)));
            end
            start = 1; cfg_we = 1'($urandom_range(0, 1)); tick();
            start = 0; cfg_we = 0;
            for (int c = 0; c < 50; c++) begin
                num_inst    = WS'($urandom_range(0, 7));
                output_port = WS'(pick_word($urandom_range(0, 3)));
                is_halted   = ($urandom_range(0, 15) == 0);
                start       = ($urandom_range(0, 24) == 0);
                cfg_we      = 1'($urandom_range(0, 1));
                cfg_idx     = IW'($urandom_range(0, 7));
                rd_idx      = IW'($urandom_range(0, 7));
                tick();
            end
            start = 0; cfg_we = 0;
            halt();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
